// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: decoder data-width codes,
// arbiter FSM states and the transaction owner tag.
package mem_port_arbiter_pkg;

  localparam logic [1:0] DATAWIDTH_BYTE  = 2'b00;
  localparam logic [1:0] DATAWIDTH_SHORT = 2'b01;
  localparam logic [1:0] DATAWIDTH_WORD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_FAULT = 2'b11
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_lsu_lane_align.sv
// Byte-enable, store-lane shift and misalignment decode for one LSU access.
// Purely combinational; reserved width code 2'b11 behaves as a word access.
module lsu_lane_align
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        width,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata_shifted,
  output logic              misaligned
);

  always_comb begin
    be         = 4'b1111;
    misaligned = 1'b0;
    case (width)
      DATAWIDTH_BYTE: begin
        be = 4'b0001 << addr_lo;
      end
      DATAWIDTH_SHORT: begin
        be         = 4'b0011 << addr_lo;
        misaligned = addr_lo[0];
      end
      default: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
    endcase
  end

  // Bytes shifted past the top lane are dropped, so unused lanes stay deterministic.
  assign wdata_shifted = wdata << {addr_lo, 3'b000};

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction
// at a time. Define MEM_ARB_FAIR_EN to bound LSU grant streaks while fetch waits.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_we,
  input  logic [1:0]        lsu_req_width,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_rdata,
  output logic              lsu_rsp_misaligned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output arb_state_e        dbg_state
);

  // Handshake: a request transfers on a rising edge where valid and ready are
  // both high. Ready is only raised for the arbitration winner in IDLE, and a
  // requester may drop valid after the transfer without affecting it.

  arb_state_e        state_q, state_d;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;

  logic              idle;
  logic              lsu_wins;
  logic              lsu_grant;
  logic              if_grant;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic              al_mis;
  logic              unused_if_addr_lo;

  assign unused_if_addr_lo = ^if_req_addr[1:0];

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .width         (lsu_req_width),
    .addr_lo       (lsu_req_addr[1:0]),
    .wdata         (lsu_req_wdata),
    .be            (al_be),
    .wdata_shifted (al_wdata),
    .misaligned    (al_mis)
  );

  // Gating with rst_n keeps both readies low while reset is asserted.
  assign idle = (state_q == ST_IDLE) && rst_n;

`ifdef MEM_ARB_FAIR_EN
  localparam int STREAK_W = $clog2(MAX_LSU_STREAK + 1);
  logic [STREAK_W-1:0] streak_q;
  logic                if_turn;

  assign if_turn  = (streak_q >= STREAK_W'(MAX_LSU_STREAK));
  assign lsu_wins = lsu_req_valid && !(if_turn && if_req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (idle) begin
      if (if_grant || !if_req_valid) begin
        streak_q <= '0;
      end else if (lsu_grant) begin
        streak_q <= streak_q + 1'b1;
      end
    end
  end
`else
  assign lsu_wins = lsu_req_valid;
`endif

  assign lsu_grant     = idle && lsu_wins;
  assign if_grant      = idle && if_req_valid && !lsu_wins;
  assign lsu_req_ready = lsu_grant;
  assign if_req_ready  = if_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (lsu_grant) begin
        owner_q <= OWNER_LSU;
        // A misaligned access never reaches the bus, so leave the bus registers alone.
        if (!al_mis) begin
          addr_q  <= {lsu_req_addr[ADDR_W-1:2], 2'b00};
          we_q    <= lsu_req_we;
          be_q    <= al_be;
          wdata_q <= al_wdata;
        end
      end else if (if_grant) begin
        owner_q <= OWNER_IF;
        addr_q  <= {if_req_addr[ADDR_W-1:2], 2'b00};
        we_q    <= 1'b0;
        be_q    <= 4'b1111;
        wdata_q <= '0;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    mem_req_valid      = 1'b0;
    if_rsp_valid       = 1'b0;
    if_rsp_data        = '0;
    lsu_rsp_valid      = 1'b0;
    lsu_rsp_rdata      = '0;
    lsu_rsp_misaligned = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lsu_grant) begin
          state_d = al_mis ? ST_FAULT : ST_ISSUE;
        end else if (if_grant) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          if (owner_q == OWNER_LSU) begin
            lsu_rsp_valid = 1'b1;
            lsu_rsp_rdata = mem_rsp_rdata;
          end else begin
            if_rsp_valid = 1'b1;
            if_rsp_data  = mem_rsp_rdata;
          end
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        lsu_rsp_valid      = 1'b1;
        lsu_rsp_misaligned = 1'b1;
        state_d            = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus randomized traffic checked by a
// byte-level memory model and expected-response queues popped by a monitor.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAX_STREAK = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_we;
  logic [1:0]  lsu_req_width;
  logic [31:0] lsu_req_wdata;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_rdata;
  logic        lsu_rsp_misaligned;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  arb_state_e  dbg_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LSU_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_we(lsu_req_we), .lsu_req_width(lsu_req_width), .lsu_req_wdata(lsu_req_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .lsu_rsp_misaligned(lsu_rsp_misaligned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // ---------------- reference memory model ----------------
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_byte(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    return {ref_byte(a + 3), ref_byte(a + 2), ref_byte(a + 1), ref_byte(a)};
  endfunction

  function automatic logic [31:0] bus_word(logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return {init_byte(a + 3), init_byte(a + 2), init_byte(a + 1), init_byte(a)};
  endfunction

  task automatic preload_word(logic [31:0] a, logic [31:0] d);
    for (int i = 0; i < 4; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    bus_mem[a] = d;
  endtask

  // ---------------- scoreboard queues ----------------
  // bus entry: {addr[100:69], we[68], be[67:64], wdata[63:32], lane_mask[31:0]}
  logic [100:0] exp_bus_q[$];
  logic [31:0]  exp_if_q[$];
  // lsu entry: {misaligned[33], check_data[32], data[31:0]}
  logic [33:0]  exp_lsu_q[$];

  // ---------------- memory-side responder ----------------
  int          ready_mode = 1;  // 0 random, 1 always, 2 never
  int          max_delay  = 0;
  bit          stray_req  = 0;
  bit          resp_hs;
  logic [31:0] resp_addr, resp_wdata, resp_data;
  logic        resp_we;
  logic [3:0]  resp_be;
  bit          resp_pend = 0;
  int          resp_cnt  = 0;

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      resp_hs    = rst_n && mem_req_valid && mem_req_ready;
      resp_addr  = mem_addr;
      resp_we    = mem_we;
      resp_be    = mem_be;
      resp_wdata = mem_wdata;
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (!rst_n) begin
        resp_pend     = 0;
        mem_req_ready = 1'b0;
      end else begin
        if (stray_req) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = $urandom;
          stray_req     = 0;
        end else if (resp_pend) begin
          if (resp_cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = resp_data;
            resp_pend     = 0;
          end else begin
            resp_cnt--;
          end
        end
        if (resp_hs) begin
          if (resp_we) begin
            logic [31:0] w;
            w = bus_word(resp_addr);
            for (int l = 0; l < 4; l++) if (resp_be[l]) w[8*l +: 8] = resp_wdata[8*l +: 8];
            bus_mem[resp_addr] = w;
            resp_data = $urandom;
          end else begin
            resp_data = bus_word(resp_addr);
          end
          resp_cnt = $urandom_range(0, max_delay);
          if (resp_cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = resp_data;
          end else begin
            resp_pend = 1;
            resp_cnt--;
          end
        end
        mem_req_ready = (ready_mode == 1) ? 1'b1 :
                        (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_req_valid && mem_req_ready) begin
          if (exp_bus_q.size() == 0) check("bus_unexpected", 1, 0);
          else begin
            logic [100:0] e;
            e = exp_bus_q.pop_front();
            check("bus_addr", mem_addr, e[100:69]);
            check("bus_we", mem_we, e[68]);
            check("bus_be", mem_be, e[67:64]);
            check("bus_wdata", mem_wdata & e[31:0], e[63:32] & e[31:0]);
          end
        end
        if (if_rsp_valid) begin
          if (exp_if_q.size() == 0) check("if_rsp_unexpected", 1, 0);
          else check("if_rsp_data", if_rsp_data, exp_if_q.pop_front());
        end
        if (lsu_rsp_valid) begin
          if (exp_lsu_q.size() == 0) check("lsu_rsp_unexpected", 1, 0);
          else begin
            logic [33:0] e;
            e = exp_lsu_q.pop_front();
            check("lsu_rsp_misaligned", lsu_rsp_misaligned, e[33]);
            if (e[32]) check("lsu_rsp_rdata", lsu_rsp_rdata, e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  bit          if_pend = 0, lsu_pend = 0;
  logic [31:0] if_addr_p = '0, lsu_addr_p = '0, lsu_wdata_p = '0;
  logic [1:0]  lsu_width_p = 2'b10;
  logic        lsu_we_p = 1'b0;
  int          streak_m = 0;
  int          last_grant_cyc = 0;
  bit          last_was_lsu = 0;
  bit          last_mis = 0;

  task automatic present();
    if_req_valid  = if_pend;
    if_req_addr   = if_addr_p;
    lsu_req_valid = lsu_pend;
    lsu_req_addr  = lsu_addr_p;
    lsu_req_we    = lsu_we_p;
    lsu_req_width = lsu_width_p;
    lsu_req_wdata = lsu_wdata_p;
  endtask

  task automatic set_lsu(logic [31:0] a, logic [1:0] w, logic we, logic [31:0] d);
    lsu_addr_p = a; lsu_width_p = w; lsu_we_p = we; lsu_wdata_p = d; lsu_pend = 1;
  endtask

  task automatic set_if(logic [31:0] a);
    if_addr_p = a; if_pend = 1;
  endtask

  task automatic push_lsu_expect();
    int nb, off;
    logic [3:0]  be;
    logic [31:0] wd, mask;
    nb  = (lsu_width_p == 2'b00) ? 1 : (lsu_width_p == 2'b01) ? 2 : 4;
    off = int'(lsu_addr_p % 4);
    last_mis = (nb == 2 && off % 2 != 0) || (nb == 4 && off != 0);
    if (last_mis) begin
      exp_lsu_q.push_back({1'b1, 1'b0, 32'h0});
    end else begin
      be = '0; wd = '0; mask = '0;
      for (int i = 0; i < nb; i++) begin
        be[off + i]            = 1'b1;
        wd[8*(off + i) +: 8]   = lsu_wdata_p[8*i +: 8];
        mask[8*(off + i) +: 8] = 8'hFF;
      end
      exp_bus_q.push_back({lsu_addr_p & ~32'h3, lsu_we_p, be, wd, lsu_we_p ? mask : 32'h0});
      if (lsu_we_p) begin
        for (int i = 0; i < nb; i++) ref_mem[lsu_addr_p + 32'(i)] = lsu_wdata_p[8*i +: 8];
        exp_lsu_q.push_back({1'b0, 1'b0, 32'h0});
      end else begin
        exp_lsu_q.push_back({1'b0, 1'b1, ref_word(lsu_addr_p & ~32'h3)});
      end
    end
  endtask

  task automatic push_if_expect();
    last_mis = 0;
    exp_bus_q.push_back({if_addr_p & ~32'h3, 1'b0, 4'hF, 32'h0, 32'h0});
    exp_if_q.push_back(ref_word(if_addr_p & ~32'h3));
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic run_step();
    int t;
    bit exp_lsu;
    present();
    t = 0;
    @(negedge clk);
    while (!(if_req_ready || lsu_req_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!(if_req_ready || lsu_req_ready)) begin
      check("grant_timeout", 0, 1);
      if_pend = 0; lsu_pend = 0;
      @(posedge clk); #1;
      present();
      return;
    end
    exp_lsu = lsu_pend;
`ifdef MEM_ARB_FAIR_EN
    if (lsu_pend && if_pend && streak_m >= MAX_STREAK) exp_lsu = 0;
`endif
    check("lsu_req_ready", lsu_req_ready, exp_lsu);
    check("if_req_ready", if_req_ready, !exp_lsu);
    last_grant_cyc = cyc;
    last_was_lsu   = lsu_req_ready;
    if (lsu_req_ready) begin
      streak_m = if_pend ? streak_m + 1 : 0;
      push_lsu_expect();
      lsu_pend = 0;
    end else begin
      streak_m = 0;
      push_if_expect();
      if_pend = 0;
    end
    @(posedge clk); #1;
    present();
    if (last_was_lsu && last_mis) begin
      @(negedge clk);
      check("fault_no_bus", mem_req_valid, 0);
      check("fault_rsp", {lsu_rsp_valid, lsu_rsp_misaligned}, 2'b11);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_bus_q.size() + exp_if_q.size() + exp_lsu_q.size()) != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_queues", exp_bus_q.size() + exp_if_q.size() + exp_lsu_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  initial begin
    #2000000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    logic [9:0] order_got, order_exp;
    bit leak, state_bad;

    rst_n = 1'b0;
    present();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_ctrl", {mem_req_valid, if_req_ready, lsu_req_ready, if_rsp_valid,
                       lsu_rsp_valid, lsu_rsp_misaligned}, 0);
    check("rst_bus", {mem_addr, mem_we, mem_be, mem_wdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch at 0x104 and back-to-back turnaround
    ready_mode = 1; max_delay = 0;
    preload_word(32'h104, 32'h0000_0013);
    set_if(32'h104);
    run_step();
    c0 = last_grant_cyc;
    set_if(32'h108);
    run_step();
    check("turnaround", last_grant_cyc - c0, 3);
    drain();

    // LSU store beats a simultaneous fetch; fetch follows
    set_if(32'h10C);
    set_lsu(32'h200, DATAWIDTH_WORD, 1'b1, 32'hDEAD_BEEF);
    run_step();
    run_step();
    drain();

    // Sub-word stores, read back, misaligned load
    set_lsu(32'h303, DATAWIDTH_BYTE, 1'b1, 32'h0000_00AB);
    run_step();
    set_lsu(32'h302, DATAWIDTH_SHORT, 1'b1, 32'h0000_1234);
    run_step();
    set_lsu(32'h300, DATAWIDTH_WORD, 1'b0, 32'h0);
    run_step();
    set_lsu(32'h201, DATAWIDTH_SHORT, 1'b0, 32'h0);
    run_step();
    set_lsu(32'h202, 2'b11, 1'b1, 32'h5555_AAAA);
    run_step();
    drain();

    // Randomized traffic
    ready_mode = 0; max_delay = 2;
    for (int s = 0; s < 300; s++) begin
      if (!if_pend && $urandom_range(0, 1) == 1) set_if(32'h100 + $urandom_range(0, 255));
      if (!lsu_pend && $urandom_range(0, 1) == 1)
        set_lsu(32'h200 + $urandom_range(0, 63), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom);
      if (!if_pend && !lsu_pend) begin
        @(posedge clk); #1;
      end else begin
        run_step();
      end
    end
    if_pend = 0; lsu_pend = 0;
    present();
    drain();
    streak_m = 0;

    // Both requesters continuously valid
    ready_mode = 1; max_delay = 0;
    for (int g = 0; g < 10; g++) begin
      if (!if_pend) set_if(32'h100 + 32'(4 * g));
      if (!lsu_pend) set_lsu(32'h220 + 32'(4 * g), DATAWIDTH_WORD, 1'b0, 32'h0);
      run_step();
      order_got[g] = last_was_lsu;
    end
    for (int g = 0; g < 10; g++) begin
`ifdef MEM_ARB_FAIR_EN
      order_exp[g] = (g % (MAX_STREAK + 1)) != MAX_STREAK;
`else
      order_exp[g] = 1'b1;
`endif
    end
    check("grant_order", order_got, order_exp);
    if_pend = 0; lsu_pend = 0;
    present();
    drain();

    // Stalled bus, then reset mid-transaction
    ready_mode = 2;
    set_lsu(32'h3F0, DATAWIDTH_WORD, 1'b1, 32'h1122_3344);
    run_step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", {mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata},
            {1'b1, 1'b1, 4'hF, 32'h3F0, 32'h1122_3344});
    end
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {mem_req_valid, if_req_ready, lsu_req_ready, if_rsp_valid,
                          lsu_rsp_valid, lsu_rsp_misaligned}, 0);
    check("midrst_bus", {mem_addr, mem_we, mem_be, mem_wdata}, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    exp_bus_q.delete(); exp_if_q.delete(); exp_lsu_q.delete();
    if_pend = 0; lsu_pend = 0;
    present();
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 1;
    @(posedge clk); #1;

    // Stray response after reset must be dropped
    stray_req = 1;
    leak = 0; state_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      leak      = leak | if_rsp_valid | lsu_rsp_valid;
      state_bad = state_bad | (dbg_state != ST_IDLE);
    end
    check("stray_rsp_ignored", leak, 0);
    check("stray_state_idle", state_bad, 0);
    @(posedge clk); #1;
    set_if(32'h104);
    run_step();
    drain();

    finish_run();
  end

endmodule
